// File: rtl/byte_engine_sched_pkg.sv
// -----------------------------------------------------------------------------
// byte_engine_sched_pkg
// Shared types and helpers for the byte-engine round-robin scheduler.
//   sched_state_e   : scheduler FSM states (IDLE, ISSUE, WAIT, RESP)
//   SCHED_N_REQ_MAX : largest requester count the scheduler is meant for
//   wrap_inc        : increment with wrap-around at a given modulus
// -----------------------------------------------------------------------------
package byte_engine_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    localparam int SCHED_N_REQ_MAX = 8;

    // Next round-robin position: value+1, folding back to 0 at the modulus.
    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/byte_engine_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick among N requesters.
//   req   in  N        request vector
//   ptr   in  log2(N)  highest-priority position for this pick
//   grant out N        one-hot winner (all zero when nothing requests)
//   idx   out log2(N)  index of the winner
//   valid out 1        at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import byte_engine_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    int            pos_i;
    logic [IW-1:0] pos;

    // Walk the ring starting at ptr; the first set request wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        pos_i = 0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos_i = (int'(ptr) + k) % N;
            pos   = IW'(pos_i);
            if (!valid && req[pos]) begin
                valid      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/byte_engine_sched.sv
// -----------------------------------------------------------------------------
// byte_engine_sched
// Shares one byte-processing engine among N_REQ requesters in round-robin
// order, one job in flight, with a done timeout guarding against a hung engine.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : per-requester level request, held until gnt
//   req_data   : packed request bytes, slice i belongs to req[i]
//   gnt        : one-hot single-cycle grant (byte captured)
//   eng_input  : byte presented to the engine, stable from grant to next grant
//   eng_start  : single-cycle engine start strobe
//   eng_out    : engine result, sampled with eng_done
//   eng_done   : engine completion pulse
//   rsp_valid  : single-cycle response strobe with rsp_id/rsp_bit/rsp_err
//   busy       : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module byte_engine_sched
    import byte_engine_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [DATA_W-1:0]         eng_input,
    output logic                      eng_start,
    input  logic                      eng_out,
    input  logic                      eng_done,
    output logic                      rsp_valid,
    output logic [$clog2(N_REQ)-1:0]  rsp_id,
    output logic                      rsp_bit,
    output logic                      rsp_err,
    output logic                      busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    sched_state_e       state, state_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [ID_W-1:0]    job_id, job_id_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;

    logic [N_REQ-1:0]   gnt_nxt;
    logic [DATA_W-1:0]  eng_input_nxt;
    logic               eng_start_nxt;
    logic               rsp_valid_nxt;
    logic [ID_W-1:0]    rsp_id_nxt;
    logic               rsp_bit_nxt;
    logic               rsp_err_nxt;

    logic [N_REQ-1:0]   arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_valid;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // State and every output are registered; a reset mid-job simply drops it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            job_id    <= '0;
            timer     <= '0;
            gnt       <= '0;
            eng_input <= '0;
            eng_start <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_bit   <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            job_id    <= job_id_nxt;
            timer     <= timer_nxt;
            gnt       <= gnt_nxt;
            eng_input <= eng_input_nxt;
            eng_start <= eng_start_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_id    <= rsp_id_nxt;
            rsp_bit   <= rsp_bit_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    // Next-state and next-output logic. Strobes default low; data registers
    // hold so eng_input stays put until the following grant. eng_done is only
    // looked at in WAIT, and it is tested before the timeout so a done on the
    // final timer cycle still counts as a good completion.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        job_id_nxt    = job_id;
        timer_nxt     = timer;
        gnt_nxt       = '0;
        eng_input_nxt = eng_input;
        eng_start_nxt = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_id_nxt    = rsp_id;
        rsp_bit_nxt   = rsp_bit;
        rsp_err_nxt   = rsp_err;

        case (state)
            IDLE: begin
                if (arb_valid) begin
                    gnt_nxt       = arb_grant;
                    eng_input_nxt = req_data[int'(arb_idx)*DATA_W +: DATA_W];
                    job_id_nxt    = arb_idx;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                eng_start_nxt = 1'b1;
                timer_nxt     = '0;
                state_nxt     = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_id_nxt    = job_id;
                    rsp_bit_nxt   = eng_out;
                    rsp_err_nxt   = 1'b0;
                    state_nxt     = RESP;
                end else if (timer == TMR_LAST) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_id_nxt    = job_id;
                    rsp_bit_nxt   = 1'b0;
                    rsp_err_nxt   = 1'b1;
                    state_nxt     = RESP;
                end else if (timer != TMR_MAX) begin
                    timer_nxt = timer + 1'b1;
                end
            end
            RESP: begin
                // Priority moves past the requester just served.
                ptr_nxt   = ID_W'(wrap_inc(int'(job_id), N_REQ));
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
